// File: rtl/axi_lite_mailbox.sv
// -----------------------------------------------------------------------------
// axi_lite_mailbox
//   AXI-Lite register mailbox between a capture-side job source and software.
//   The capture side posts a 128-bit job (start/pt). Software reads PT0-PT3,
//   writes the result into CT0-CT3, then writes DONE. DONE publishes the result
//   on ct and releases busy. A start that arrives while a job is outstanding is
//   dropped and counted in a saturating counter that clears on a STATUS read.
//
// Ports
//   clk, reset          : single clock, synchronous active-high reset
//   mem_axi_aw* / w* / b*: AXI-Lite write address, data and response
//   mem_axi_ar* / r*    : AXI-Lite read address and data
//   start, pt           : job request pulse and its 128-bit input
//   ct                  : job result, updated on DONE
//   busy                : job outstanding (accepted start until DONE)
//   irq                 : pending AND irq_en
// -----------------------------------------------------------------------------
module axi_lite_mailbox #(
   parameter int DECODE_BITS = 8,
   parameter int DROP_W      = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         mem_axi_awvalid,
   output logic         mem_axi_awready,
   input  logic [31:0]  mem_axi_awaddr,
   input  logic [2:0]   mem_axi_awprot,
   input  logic         mem_axi_wvalid,
   output logic         mem_axi_wready,
   input  logic [31:0]  mem_axi_wdata,
   input  logic [3:0]   mem_axi_wstrb,
   output logic         mem_axi_bvalid,
   input  logic         mem_axi_bready,
   input  logic         mem_axi_arvalid,
   output logic         mem_axi_arready,
   input  logic [31:0]  mem_axi_araddr,
   input  logic [2:0]   mem_axi_arprot,
   output logic         mem_axi_rvalid,
   input  logic         mem_axi_rready,
   output logic [31:0]  mem_axi_rdata,
   input  logic         start,
   input  logic [127:0] pt,
   output logic [127:0] ct,
   output logic         busy,
   output logic         irq
);

   // Word index = addr[DECODE_BITS-1:2]; the upper index bits select the group
   // (PT at 0x10-0x1C, CT at 0x20-0x2C) and the low two bits select the word.
   localparam int IDX_W = DECODE_BITS - 2;
   localparam int GRP_W = IDX_W - 2;
   localparam logic [IDX_W-1:0] IDX_STATUS = IDX_W'(0);
   localparam logic [IDX_W-1:0] IDX_DONE   = IDX_W'(1);
   localparam logic [IDX_W-1:0] IDX_IRQ_EN = IDX_W'(2);
   localparam logic [GRP_W-1:0] GRP_PT     = GRP_W'(1);
   localparam logic [GRP_W-1:0] GRP_CT     = GRP_W'(2);

   typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

   state_t             state;
   logic               ports_en;   // low in reset and for the first cycle after
   logic               aw_held, w_held, bvalid_q, rvalid_q;
   logic [IDX_W-1:0]   aw_idx_q;
   logic [31:0]        w_data_q;
   logic [3:0]         w_strb_q;
   logic [31:0]        rdata_q, rd_word;
   logic               pending, irq_en;
   logic [DROP_W-1:0]  drop_cnt;
   logic [3:0][31:0]   pt_q, ct_q;

   logic [IDX_W-1:0]   ar_idx;
   logic               aw_fire, w_fire, ar_fire, wr_commit;
   logic               done_wr, start_drop, status_rd;

   logic unused_ok;
   assign unused_ok = ^{mem_axi_awprot, mem_axi_arprot,
                        mem_axi_awaddr[31:DECODE_BITS], mem_axi_awaddr[1:0],
                        mem_axi_araddr[31:DECODE_BITS], mem_axi_araddr[1:0]};

   assign mem_axi_awready = ports_en && !aw_held && !bvalid_q;
   assign mem_axi_wready  = ports_en && !w_held  && !bvalid_q;
   assign mem_axi_arready = ports_en && !rvalid_q;
   assign mem_axi_bvalid  = bvalid_q;
   assign mem_axi_rvalid  = rvalid_q;
   assign mem_axi_rdata   = rdata_q;
   assign busy            = (state == S_BUSY);
   assign irq             = pending && irq_en;

   assign aw_fire    = mem_axi_awvalid && mem_axi_awready;
   assign w_fire     = mem_axi_wvalid  && mem_axi_wready;
   assign ar_fire    = mem_axi_arvalid && mem_axi_arready;
   assign ar_idx     = mem_axi_araddr[DECODE_BITS-1:2];
   // Register update happens once, on the edge where both halves are held.
   assign wr_commit  = aw_held && w_held && !bvalid_q;
   assign done_wr    = wr_commit && (aw_idx_q == IDX_DONE) && w_strb_q[0] && w_data_q[0];
   assign start_drop = start && (state == S_BUSY);
   assign status_rd  = ar_fire && (ar_idx == IDX_STATUS);

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  strb);
      logic [31:0] res;
      for (int b = 0; b < 4; b++)
         res[8*b +: 8] = strb[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
      return res;
   endfunction

   // Write channel: AW and W captured independently, response held until taken.
   always_ff @(posedge clk) begin
      // NOTE: flops use <= so every block sees pre-edge values of the others.
      if (reset) begin
         ports_en <= 1'b0;
         aw_held  <= 1'b0;
         w_held   <= 1'b0;
         bvalid_q <= 1'b0;
         aw_idx_q <= '0;
         w_data_q <= '0;
         w_strb_q <= '0;
      end else begin
         ports_en <= 1'b1;
         if (aw_fire) begin
            aw_held  <= 1'b1;
            aw_idx_q <= mem_axi_awaddr[DECODE_BITS-1:2];
         end
         if (w_fire) begin
            w_held   <= 1'b1;
            w_data_q <= mem_axi_wdata;
            w_strb_q <= mem_axi_wstrb;
         end
         if (wr_commit) begin
            bvalid_q <= 1'b1;
         end else if (bvalid_q && mem_axi_bready) begin
            bvalid_q <= 1'b0;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
         end
      end
   end

   // Read data mux, sampled into rdata_q on the AR handshake.
   always_comb begin
      // NOTE: default first so every path assigns rd_word and no latch forms.
      rd_word = '0;
      if (ar_idx == IDX_STATUS) begin
         rd_word[8 +: DROP_W] = drop_cnt;
         rd_word[1]           = busy;
         rd_word[0]           = pending;
      end else if (ar_idx == IDX_IRQ_EN) begin
         rd_word[0] = irq_en;
      end else if (ar_idx[IDX_W-1:2] == GRP_PT) begin
         rd_word = pt_q[ar_idx[1:0]];
      end else if (ar_idx[IDX_W-1:2] == GRP_CT) begin
         rd_word = ct_q[ar_idx[1:0]];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
      end else if (ar_fire) begin
         rvalid_q <= 1'b1;
         rdata_q  <= rd_word;
      end else if (rvalid_q && mem_axi_rready) begin
         rvalid_q <= 1'b0;
      end
   end

   // Register file and job FSM.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         pending  <= 1'b0;
         irq_en   <= 1'b0;
         drop_cnt <= '0;
         // NOTE: PT/CT word arrays are plain flops and are cleared like any other state.
         pt_q     <= '0;
         ct_q     <= '0;
         ct       <= '0;
      end else begin
         if (wr_commit) begin
            if (aw_idx_q == IDX_IRQ_EN && w_strb_q[0])
               irq_en <= w_data_q[0];
            if (aw_idx_q[IDX_W-1:2] == GRP_CT)
               ct_q[aw_idx_q[1:0]] <= merge_bytes(ct_q[aw_idx_q[1:0]], w_data_q, w_strb_q);
         end

         case (state)
            S_IDLE: if (start) begin
               pt_q    <= pt;
               pending <= 1'b1;
               state   <= S_BUSY;
            end
            S_BUSY: if (done_wr) begin
               ct      <= ct_q;
               pending <= 1'b0;
               state   <= S_IDLE;
            end
         endcase

         // A STATUS read returns the old count and clears it; a drop on the
         // same edge is not lost.
         if (status_rd)
            drop_cnt <= start_drop ? DROP_W'(1) : '0;
         else if (start_drop && drop_cnt != '1)
            drop_cnt <= drop_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_axi_lite_mailbox.sv
module tb_axi_lite_mailbox;

   logic         clk = 1'b0;
   logic         reset;
   logic         awvalid, awready, wvalid, wready, bvalid, bready;
   logic         arvalid, arready, rvalid, rready;
   logic [31:0]  awaddr, wdata, araddr, rdata;
   logic [3:0]   wstrb;
   logic [2:0]   awprot, arprot;
   logic         start, busy, irq;
   logic [127:0] pt, ct;

   int n_checks = 0;
   int n_errors = 0;
   logic         busy_at_b;
   logic [127:0] ct_at_b;
   logic [31:0]  rd_val;

   always #5 clk = ~clk;

   axi_lite_mailbox #(.DECODE_BITS(8), .DROP_W(8)) dut (
      .clk(clk), .reset(reset),
      .mem_axi_awvalid(awvalid), .mem_axi_awready(awready),
      .mem_axi_awaddr(awaddr), .mem_axi_awprot(awprot),
      .mem_axi_wvalid(wvalid), .mem_axi_wready(wready),
      .mem_axi_wdata(wdata), .mem_axi_wstrb(wstrb),
      .mem_axi_bvalid(bvalid), .mem_axi_bready(bready),
      .mem_axi_arvalid(arvalid), .mem_axi_arready(arready),
      .mem_axi_araddr(araddr), .mem_axi_arprot(arprot),
      .mem_axi_rvalid(rvalid), .mem_axi_rready(rready),
      .mem_axi_rdata(rdata),
      .start(start), .pt(pt), .ct(ct), .busy(busy), .irq(irq)
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // All tasks start and end just after a falling edge.
   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb);
      int   n = 0;
      logic aw_done = 1'b0, w_done = 1'b0, aw_f, w_f;
      awaddr = addr; wdata = data; wstrb = strb;
      awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
      while (!(aw_done && w_done) && n < 20) begin
         aw_f = awvalid && awready;
         w_f  = wvalid && wready;
         @(negedge clk);
         if (aw_f) begin awvalid = 1'b0; aw_done = 1'b1; end
         if (w_f)  begin wvalid  = 1'b0; w_done  = 1'b1; end
         n++;
      end
      while (!bvalid && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("wr_bvalid", bvalid, 1'b1);
      busy_at_b = busy;
      ct_at_b   = ct;
      @(negedge clk);
      bready = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
   endtask

   task automatic axi_read(input logic [31:0] addr, output logic [31:0] data);
      int   n = 0;
      logic ar_done = 1'b0, ar_f;
      araddr = addr; arvalid = 1'b1; rready = 1'b1;
      while (!ar_done && n < 20) begin
         ar_f = arvalid && arready;
         @(negedge clk);
         if (ar_f) begin arvalid = 1'b0; ar_done = 1'b1; end
         n++;
      end
      while (!rvalid && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("rd_rvalid", rvalid, 1'b1);
      data = rdata;
      @(negedge clk);
      rready = 1'b0; arvalid = 1'b0;
   endtask

   task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
      logic [31:0] v;
      axi_read(addr, v);
      check(tag, v, exp);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
      awaddr = 0; wdata = 0; araddr = 0; wstrb = 0; awprot = 0; arprot = 0;
      start = 0; pt = '0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_awready", awready, 0);
      check("rst_wready",  wready,  0);
      check("rst_arready", arready, 0);
      check("rst_bvalid",  bvalid,  0);
      check("rst_rvalid",  rvalid,  0);
      check("rst_busy",    busy,    0);
      check("rst_irq",     irq,     0);
      check("rst_ct",      ct,      0);
      check("rst_rdata",   rdata,   0);
      reset = 1'b0;
      @(negedge clk);
      check("post_rst_awready", awready, 1);
      check("post_rst_wready",  wready,  1);
      check("post_rst_arready", arready, 1);

      // Job accept and PT readback
      pt = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("start_busy", busy, 1);
      read_check("pt0",        32'h10,  32'h03020100);
      read_check("pt3",        32'h1C,  32'h0F0E0D0C);
      read_check("status_job", 32'h00,  32'h00000003);
      read_check("done_rd0",   32'h04,  32'h00000000);
      read_check("unmapped",   32'h30,  32'h00000000);
      read_check("hi_ignored", 32'h110, 32'h03020100);

      // W three cycles before AW, partial strobe, stalled response
      wdata = 32'hDEADBEEF; wstrb = 4'h3; wvalid = 1'b1; bready = 1'b0;
      @(negedge clk);
      check("w_taken", wready, 0);
      wvalid = 1'b0;
      repeat (2) @(negedge clk);
      check("w_first_no_b", bvalid, 0);
      awaddr = 32'h20; awvalid = 1'b1;
      @(negedge clk);
      awvalid = 1'b0;
      check("b_not_yet", bvalid, 0);
      @(negedge clk);
      check("b_rise", bvalid, 1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("b_hold", bvalid, 1);
      end
      check("aw_blocked", awready, 0);
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
      check("b_clear", bvalid, 0);
      read_check("ct0_strb", 32'h20, 32'h0000BEEF);

      // CT fill and DONE
      axi_write(32'h20, 32'h1, 4'hF);
      axi_write(32'h24, 32'h2, 4'hF);
      axi_write(32'h28, 32'h3, 4'hF);
      axi_write(32'h2C, 32'h4, 4'hF);
      check("ct_before_done", ct, 0);
      check("busy_before_done", busy, 1);
      axi_write(32'h04, 32'h1, 4'h1);
      check("done_busy_edge", busy_at_b, 0);
      check("done_ct_edge", ct_at_b, 128'h00000004_00000003_00000002_00000001);
      read_check("status_done", 32'h00, 32'h00000000);

      // Strobes, RO writes, DONE while idle
      axi_write(32'h24, 32'hAABBCCDD, 4'h4);
      read_check("ct1_byte2", 32'h24, 32'h00BB0002);
      axi_write(32'h28, 32'hFFFFFFFF, 4'h0);
      read_check("ct2_strb0", 32'h28, 32'h00000003);
      axi_write(32'h10, 32'h12345678, 4'hF);
      read_check("pt0_ro", 32'h10, 32'h03020100);
      axi_write(32'h04, 32'h1, 4'h1);
      check("idle_done_ct", ct, 128'h00000004_00000003_00000002_00000001);
      read_check("idle_done_st", 32'h00, 32'h00000000);

      // Dropped starts and saturation
      pt = 128'h11111111_22222222_33333333_44444444;
      start = 1'b1;
      @(negedge clk);
      pt = '1;
      repeat (3) @(negedge clk);
      start = 1'b0;
      read_check("drop3",       32'h00, 32'h00000303);
      read_check("drop_clr",    32'h00, 32'h00000003);
      start = 1'b1;
      repeat (300) @(negedge clk);
      start = 1'b0;
      read_check("drop_sat",    32'h00, 32'h0000FF03);
      read_check("drop_sat_clr", 32'h00, 32'h00000003);
      read_check("pt0_kept",    32'h10, 32'h44444444);

      // STATUS read and a drop on the same edge
      araddr = 32'h00; arvalid = 1'b1; rready = 1'b0; start = 1'b1;
      @(negedge clk);
      arvalid = 1'b0; start = 1'b0;
      check("st_edge_rv", rvalid, 1);
      check("st_edge_val", rdata, 32'h00000003);
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
      read_check("st_edge_after", 32'h00, 32'h00000103);

      // Read and write of CT3 completing on the same edge
      awaddr = 32'h2C; wdata = 32'h55; wstrb = 4'hF;
      awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      araddr = 32'h2C; arvalid = 1'b1; rready = 1'b0;
      @(negedge clk);
      arvalid = 1'b0;
      check("rw_b",   bvalid, 1);
      check("rw_rv",  rvalid, 1);
      check("rw_old", rdata,  32'h00000004);
      rready = 1'b1; bready = 1'b1;
      @(negedge clk);
      rready = 1'b0; bready = 1'b0;
      check("rw_b_clr", bvalid, 0);
      check("rw_r_clr", rvalid, 0);
      read_check("ct3_new", 32'h2C, 32'h00000055);
      axi_write(32'h04, 32'h1, 4'h1);
      check("ct_job2", ct, 128'h00000055_00000003_00BB0002_00000001);

      // Interrupt
      axi_write(32'h08, 32'h1, 4'h1);
      check("irq_no_pend", irq, 0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("irq_set", irq, 1);
      read_check("irq_en_rd", 32'h08, 32'h00000001);
      axi_write(32'h04, 32'h1, 4'h1);
      check("irq_clr", irq, 0);

      // start and DONE on the same edge while busy
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      awaddr = 32'h04; wdata = 32'h1; wstrb = 4'h1;
      awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("sd_busy", busy, 0);
      check("sd_b", bvalid, 1);
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
      read_check("sd_status", 32'h00, 32'h00000100);

      // Reset during an outstanding read
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      araddr = 32'h2C; arvalid = 1'b1; rready = 1'b0;
      @(negedge clk);
      arvalid = 1'b0;
      check("pre_rst_rv", rvalid, 1);
      check("pre_rst_irq", irq, 1);
      reset = 1'b1;
      @(negedge clk);
      check("mid_rst_rv",   rvalid,  0);
      check("mid_rst_aw",   awready, 0);
      check("mid_rst_ar",   arready, 0);
      check("mid_rst_busy", busy,    0);
      check("mid_rst_irq",  irq,     0);
      check("mid_rst_ct",   ct,      0);
      check("mid_rst_rd",   rdata,   0);
      reset = 1'b0;
      @(negedge clk);
      check("after_rst_ar", arready, 1);
      check("after_rst_rv", rvalid,  0);
      read_check("after_rst_ct3", 32'h2C, 32'h00000000);
      read_check("after_rst_ien", 32'h08, 32'h00000000);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
